mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Single-port byte-wide RAM arbiter between IF (instruction fetch) and MEM (load/store) stages.
//  Serialises 1/2/4-byte accesses into byte transfers on the RAM bus.
//  Raises stallreq_if / stallreq_mem toward the stall controller while a request is pending.
//  MEM has priority over IF.
// PARAMETERS
//  ADDR_W   32  address width for the RAM bus and both request ports
//  DATA_W   32  request data width; must be 32 (4 byte lanes)
// PORTS
//  clk           in   1   system clock, all state on rising edge
//  rst           in   1   synchronous, active-high reset
//  if_req        in   1   IF fetch request, level, held until if_done
//  if_addr       in   32  fetch address, stable while if_req
//  if_data       out  32  fetched instruction, valid while if_done
//  if_done       out  1   1-cycle pulse: fetch complete
//  mem_req       in   1   MEM access request, level, held until mem_done
//  mem_we        in   1   1=store, 0=load
//  mem_len       in   2   00=byte 01=half 11=word (10 treated as word)
//  mem_addr      in   32  access address
//  mem_wdata     in   32  store data, byte k = [8k+7:8k]
//  mem_rdata     out  32  load data, zero-extended, valid while mem_done
//  mem_done      out  1   1-cycle pulse: access complete
//  ram_a         out  32  RAM byte address
//  ram_dout      out  8   RAM write byte
//  ram_wr        out  1   RAM write strobe (1=write this cycle)
//  ram_din       in   8   RAM read byte, valid 1 cycle after ram_a presented with ram_wr=0
//  stallreq_if   out  1   = if_req & ~if_done (combinational)
//  stallreq_mem  out  1   = mem_req & ~mem_done (combinational)
// BEHAVIOUR
//  FSM states: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
//  Reset (sync): state=IDLE, cnt=0; all registered outputs = 0 (ram_a, ram_dout, ram_wr, if_data, mem_rdata, if_done, mem_done).
//  Reset mid-transfer aborts at that edge; no further ram_wr is issued; partial data is discarded.
//  IDLE arbitration at each edge:
//   - mem_req wins over if_req.
//   - Store: -> MEM_WR. Load: -> MEM_RD. Fetch: -> IF_RD.
//   - The accept edge latches addr, len and wdata, then drives ram_a=addr and cnt=0.
//  N bytes: N=1/2/4 from mem_len; IF is always N=4. ram_a = addr+k, mod 2^32 (wraps at 0xFFFFFFFF).
//  Read (IF_RD/MEM_RD):
//   - Byte k is presented in cycle k after accept; ram_din is captured into lane k at the following edge.
//   - The last capture edge sets done=1, data out valid, state->DONE.
//   - Latency from accept edge to done high: N cycles. Unused upper lanes = 0.
//  Write (MEM_WR):
//   - ram_wr=1 with ram_dout=wdata lane k and ram_a=addr+k for cycles 0..N-1 after accept.
//   - The edge ending byte N-1 drops ram_wr, sets mem_done, state->DONE.
//  DONE: done pulse high exactly 1 cycle; no request is accepted; next edge -> IDLE.
//   - The requester must drop or change req while done is high.
//  ram_wr is 0 in every state except MEM_WR.
//  if_req/mem_req dropped mid-transfer: the transfer still completes and done still pulses.
//  stallreq_* are combinational and deassert in the same cycle done is high.
// CONFIGURATION
//  MEM_CTRL_IF_ABORT_EN defined:
//   - In IF_RD, mem_req=1 at an edge aborts the fetch: captured bytes discarded, no if_done.
//   - That same edge behaves as IDLE acceptance of the MEM request.
//   - The fetch restarts from byte 0 after the MEM DONE cycle.
//  Undefined: IF_RD always runs to completion; MEM waits until IDLE.
// TESTING
//  1. Word fetch: if_req=1, if_addr=0x100, RAM[0x100..0x103]=13,00,00,00 -> if_done at 4th cycle after accept, if_data=0x00000013, stallreq_if low that cycle.
//  2. Byte store: mem_req=1, we=1, len=00, addr=0x20, wdata=0xAABBCCDD -> one cycle ram_wr=1, ram_a=0x20, ram_dout=0xDD; mem_done next cycle; RAM[0x21] untouched.
//  3. Half load at wrap: addr=0xFFFFFFFF, RAM[0xFFFFFFFF]=0x34, RAM[0]=0x12 -> ram_a 0xFFFFFFFF then 0x0; mem_rdata=0x00001234.
//  4. Simultaneous if_req and mem_req in IDLE: MEM served first (mem_done), then IF accepted after DONE; stallreq_if high throughout MEM.
//  5. mem_req raised 2 cycles into a fetch: with MEM_CTRL_IF_ABORT_EN, MEM accepted at that edge, fetch restarts at byte 0; without it, if_done first, then MEM.
//  6. rst=1 during a word store after byte 1: ram_wr=0 from the next cycle on, state IDLE, all outputs 0, RAM[addr+2..3] unchanged.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port byte-wide RAM arbiter serialising IF fetches and MEM loads/stores.
// Optional macro MEM_CTRL_IF_ABORT_EN lets a MEM request abort an in-flight fetch.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din,
  output logic              stallreq_if,
  output logic              stallreq_mem
);

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic [1:0]        last;
  logic [1:0]        mem_last;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rbuf;
  logic [DATA_W-1:0] rbuf_next;
  logic [7:0]        wbyte_next;
  logic              accept_mem;

  // last is the index of the final byte: 0, 1 or 3 (len 10 behaves as a word)
  assign mem_last = (mem_len == 2'b00) ? 2'd0 :
                    (mem_len == 2'b01) ? 2'd1 : 2'd3;

`ifdef MEM_CTRL_IF_ABORT_EN
  assign accept_mem = mem_req && (state == IDLE || state == IF_RD);
`else
  assign accept_mem = mem_req && (state == IDLE);
`endif

  assign stallreq_if  = if_req & ~if_done;
  assign stallreq_mem = mem_req & ~mem_done;

  always_comb begin
    rbuf_next = rbuf;
    case (cnt)
      2'd0: rbuf_next[7:0]   = ram_din;
      2'd1: rbuf_next[15:8]  = ram_din;
      2'd2: rbuf_next[23:16] = ram_din;
      default: rbuf_next[31:24] = ram_din;
    endcase
  end

  // byte to present after the current one completes
  always_comb begin
    case (cnt)
      2'd0: wbyte_next = wdata[15:8];
      2'd1: wbyte_next = wdata[23:16];
      2'd2: wbyte_next = wdata[31:24];
      default: wbyte_next = wdata[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= '0;
      wdata     <= '0;
      rbuf      <= '0;
      ram_a     <= '0;
      ram_dout  <= '0;
      ram_wr    <= 1'b0;
      if_data   <= '0;
      mem_rdata <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      if (accept_mem) begin
        cnt      <= '0;
        last     <= mem_last;
        wdata    <= mem_wdata;
        rbuf     <= '0;
        ram_a    <= mem_addr;
        ram_dout <= mem_wdata[7:0];
        ram_wr   <= mem_we;
        state    <= mem_we ? MEM_WR : MEM_RD;
      end else begin
        case (state)
          IDLE: begin
            if (if_req) begin
              cnt   <= '0;
              last  <= 2'd3;
              rbuf  <= '0;
              ram_a <= if_addr;
              state <= IF_RD;
            end
          end
          IF_RD, MEM_RD: begin
            rbuf <= rbuf_next;
            if (cnt == last) begin
              if (state == IF_RD) begin
                if_data <= rbuf_next;
                if_done <= 1'b1;
              end else begin
                mem_rdata <= rbuf_next;
                mem_done  <= 1'b1;
              end
              state <= DONE;
            end else begin
              cnt   <= cnt + 2'd1;
              ram_a <= ram_a + ADDR_W'(1);
            end
          end
          MEM_WR: begin
            if (cnt == last) begin
              ram_wr   <= 1'b0;
              mem_done <= 1'b1;
              state    <= DONE;
            end else begin
              cnt      <= cnt + 2'd1;
              ram_a    <= ram_a + ADDR_W'(1);
              ram_dout <= wbyte_next;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed stimulus against a byte-RAM model with a transaction-level reference.
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic        stallreq_if;
  logic        stallreq_mem;

  int checks = 0;
  int errors = 0;

  logic [7:0] dut_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] dut_rd(input logic [31:0] a);
    if (dut_mem.exists(a)) return dut_mem[a];
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 8'h00;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    dut_mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // the RAM writes the byte presented during the cycle that this edge ends
  always @(posedge clk) begin
    if (ram_wr === 1'b1) dut_mem[ram_a] = ram_dout;
  end

  always @(negedge clk) begin
    if (^ram_a === 1'bx) ram_din = 8'h00;
    else ram_din = dut_rd(ram_a);
  end

  // Reference: a transaction accepted at edge t_a owns cycles t_a..t_a+n-1 for bytes,
  // pulses done in cycle t_a+n, and the controller is idle again the cycle after.
  int          cyc = 0;
  bit          seen_rst = 0;
  bit          rst_hit = 0;
  bit          act = 0;
  int          kind = 0;
  int          t_n = 0;
  int          t_a = 0;
  logic [31:0] t_addr = '0;
  logic [31:0] t_wdata = '0;

  always @(negedge clk) begin
    int          k;
    bit          done_now;
    bit          exp_if_done;
    bit          exp_mem_done;
    bit          can_abort;
    logic [31:0] exp_data;
    logic [7:0]  wb;
    cyc++;
    done_now = 0;
    exp_if_done = 0;
    exp_mem_done = 0;
    if (seen_rst) begin
      if (rst_hit) begin
        checkOutput("reset ram_a", ram_a, 32'h0);
        checkOutput("reset ram_dout", 32'(ram_dout), 32'h0);
        checkOutput("reset ram_wr", 32'(ram_wr), 32'h0);
        checkOutput("reset if_data", if_data, 32'h0);
        checkOutput("reset mem_rdata", mem_rdata, 32'h0);
      end else if (act) begin
        k = cyc - t_a;
        if (k < t_n) begin
          checkOutput("model ram_a", ram_a, t_addr + 32'(k));
          if (kind == 2) begin
            wb = 8'(t_wdata >> (8 * k));
            checkOutput("model ram_wr", 32'(ram_wr), 32'h1);
            checkOutput("model ram_dout", 32'(ram_dout), 32'(wb));
            ref_mem[t_addr + 32'(k)] = wb;
          end else begin
            checkOutput("model ram_wr", 32'(ram_wr), 32'h0);
          end
        end else begin
          done_now = 1;
          act = 0;
          checkOutput("model ram_wr at done", 32'(ram_wr), 32'h0);
          exp_data = '0;
          for (int i = 0; i < t_n; i++)
            exp_data = exp_data | (32'(ref_rd(t_addr + 32'(i))) << (8 * i));
          if (kind == 0) begin
            exp_if_done = 1;
            checkOutput("model if_data", if_data, exp_data);
          end else begin
            exp_mem_done = 1;
            if (kind == 1) checkOutput("model mem_rdata", mem_rdata, exp_data);
          end
        end
      end else begin
        checkOutput("idle ram_wr", 32'(ram_wr), 32'h0);
      end
      checkOutput("model if_done", 32'(if_done), 32'(exp_if_done));
      checkOutput("model mem_done", 32'(mem_done), 32'(exp_mem_done));
      checkOutput("model stallreq_if", 32'(stallreq_if), 32'(if_req & ~exp_if_done));
      checkOutput("model stallreq_mem", 32'(stallreq_mem), 32'(mem_req & ~exp_mem_done));
    end
    rst_hit = 0;
    if (rst === 1'b1) begin
      seen_rst = 1;
      rst_hit = 1;
      act = 0;
    end else if (seen_rst && !done_now) begin
      can_abort = 0;
`ifdef MEM_CTRL_IF_ABORT_EN
      can_abort = act && (kind == 0) && ((cyc - t_a) < t_n);
`endif
      if ((!act || can_abort) && mem_req === 1'b1) begin
        act = 1;
        kind = mem_we ? 2 : 1;
        t_n = (mem_len == 2'b00) ? 1 : (mem_len == 2'b01) ? 2 : 4;
        t_a = cyc + 1;
        t_addr = mem_addr;
        t_wdata = mem_wdata;
      end else if (!act && if_req === 1'b1) begin
        act = 1;
        kind = 0;
        t_n = 4;
        t_a = cyc + 1;
        t_addr = if_addr;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic mr,
                               input logic we, input logic [1:0] len,
                               input logic [31:0] ma, input logic [31:0] wd);
    if_req    = ifr;
    if_addr   = ifa;
    mem_req   = mr;
    mem_we    = we;
    mem_len   = len;
    mem_addr  = ma;
    mem_wdata = wd;
  endtask

  // edges counted from the request being raised; -1 means the pulse never came
  task automatic waitDone(input bit want_mem, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      step();
      n++;
      if ((want_mem ? mem_done : if_done) === 1'b1) return;
    end
    n = -1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1);
  end

  initial begin
    int          n;
    int          if_seen;
    int          mem_seen;
    logic [31:0] got_if;
    logic [31:0] got_mem;
    rst = 1'b1;
    applyStimulus(0, 32'h0, 0, 0, 2'b00, 32'h0, 32'h0);
    preload(32'h100, 8'h13); preload(32'h101, 8'h00);
    preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    preload(32'h20, 8'h11);  preload(32'h21, 8'h5A);
    preload(32'hFFFFFFFF, 8'h34); preload(32'h0, 8'h12);
    preload(32'h200, 8'h78); preload(32'h201, 8'h56);
    preload(32'h202, 8'h34); preload(32'h203, 8'h12);
    preload(32'h300, 8'h9C);
    preload(32'h400, 8'hA1); preload(32'h401, 8'hB2);
    preload(32'h402, 8'hC3); preload(32'h403, 8'hD4);
    preload(32'h500, 8'h77);
    preload(32'h40, 8'hE0); preload(32'h41, 8'hE1);
    preload(32'h42, 8'hE2); preload(32'h43, 8'hE3);
    step(); step(); step();
    checkOutput("post-reset ram_wr", 32'(ram_wr), 32'h0);
    checkOutput("post-reset if_done", 32'(if_done), 32'h0);
    rst = 1'b0;
    step();

    $display("[TB] word fetch at 0x100");
    applyStimulus(1, 32'h100, 0, 0, 2'b00, 32'h0, 32'h0);
    waitDone(0, 20, n);
    checkOutput("fetch latency", 32'(n), 32'd5);
    checkOutput("fetch if_data", if_data, 32'h00000013);
    checkOutput("fetch stallreq_if at done", 32'(stallreq_if), 32'h0);
    applyStimulus(0, 32'h0, 0, 0, 2'b00, 32'h0, 32'h0);
    step();

    $display("[TB] byte store at 0x20");
    applyStimulus(0, 32'h0, 1, 1, 2'b00, 32'h20, 32'hAABBCCDD);
    step();
    checkOutput("store ram_wr", 32'(ram_wr), 32'h1);
    checkOutput("store ram_a", ram_a, 32'h20);
    checkOutput("store ram_dout", 32'(ram_dout), 32'hDD);
    step();
    checkOutput("store mem_done", 32'(mem_done), 32'h1);
    checkOutput("store ram_wr dropped", 32'(ram_wr), 32'h0);
    applyStimulus(0, 32'h0, 0, 0, 2'b00, 32'h0, 32'h0);
    step();
    checkOutput("store RAM[0x20]", 32'(dut_rd(32'h20)), 32'hDD);
    checkOutput("store RAM[0x21] untouched", 32'(dut_rd(32'h21)), 32'h5A);

    $display("[TB] half load across address wrap");
    applyStimulus(0, 32'h0, 1, 0, 2'b01, 32'hFFFFFFFF, 32'h0);
    step();
    checkOutput("wrap ram_a byte0", ram_a, 32'hFFFFFFFF);
    step();
    checkOutput("wrap ram_a byte1", ram_a, 32'h00000000);
    step();
    checkOutput("wrap mem_done", 32'(mem_done), 32'h1);
    checkOutput("wrap mem_rdata", mem_rdata, 32'h00001234);
    applyStimulus(0, 32'h0, 0, 0, 2'b00, 32'h0, 32'h0);
    step();

    $display("[TB] simultaneous IF and MEM requests");
    applyStimulus(1, 32'h200, 1, 0, 2'b00, 32'h300, 32'h0);
    waitDone(1, 20, n);
    checkOutput("arb mem latency", 32'(n), 32'd2);
    checkOutput("arb mem_rdata", mem_rdata, 32'h0000009C);
    checkOutput("arb stallreq_if during mem", 32'(stallreq_if), 32'h1);
    checkOutput("arb no if_done yet", 32'(if_done), 32'h0);
    mem_req = 1'b0;
    waitDone(0, 20, n);
    checkOutput("arb if latency after mem", 32'(n), 32'd6);
    checkOutput("arb if_data", if_data, 32'h12345678);
    applyStimulus(0, 32'h0, 0, 0, 2'b00, 32'h0, 32'h0);
    step();

    $display("[TB] word load with len=10");
    applyStimulus(0, 32'h0, 1, 0, 2'b10, 32'h200, 32'h0);
    waitDone(1, 20, n);
    checkOutput("len10 latency", 32'(n), 32'd5);
    checkOutput("len10 mem_rdata", mem_rdata, 32'h12345678);
    applyStimulus(0, 32'h0, 0, 0, 2'b00, 32'h0, 32'h0);
    step();

    $display("[TB] MEM request two cycles into a fetch");
    if_seen = -1;
    mem_seen = -1;
    got_if = '0;
    got_mem = '0;
    applyStimulus(1, 32'h400, 0, 0, 2'b00, 32'h0, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (if_done === 1'b1 && if_seen < 0) begin
        if_seen = i;
        got_if = if_data;
        if_req = 1'b0;
      end
      if (mem_done === 1'b1 && mem_seen < 0) begin
        mem_seen = i;
        got_mem = mem_rdata;
        mem_req = 1'b0;
      end
      if (i == 3) begin
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_len  = 2'b00;
        mem_addr = 32'h500;
      end
    end
`ifdef MEM_CTRL_IF_ABORT_EN
    checkOutput("abort mem_done cycle", 32'(mem_seen), 32'd5);
    checkOutput("abort if_done cycle", 32'(if_seen), 32'd11);
`else
    checkOutput("noabort if_done cycle", 32'(if_seen), 32'd5);
    checkOutput("noabort mem_done cycle", 32'(mem_seen), 32'd8);
`endif
    checkOutput("overlap if_data", got_if, 32'hD4C3B2A1);
    checkOutput("overlap mem_rdata", got_mem, 32'h00000077);

    $display("[TB] reset during a word store");
    applyStimulus(0, 32'h0, 1, 1, 2'b11, 32'h40, 32'h44332211);
    step();
    checkOutput("rst-store byte0 ram_dout", 32'(ram_dout), 32'h11);
    step();
    checkOutput("rst-store byte1 ram_dout", 32'(ram_dout), 32'h22);
    rst = 1'b1;
    step();
    rst = 1'b0;
    applyStimulus(0, 32'h0, 0, 0, 2'b00, 32'h0, 32'h0);
    checkOutput("rst-store ram_wr", 32'(ram_wr), 32'h0);
    checkOutput("rst-store ram_a", ram_a, 32'h0);
    checkOutput("rst-store if_data", if_data, 32'h0);
    checkOutput("rst-store mem_done", 32'(mem_done), 32'h0);
    step();
    step();
    checkOutput("rst-store ram_wr stays low", 32'(ram_wr), 32'h0);
    checkOutput("rst-store RAM[0x40]", 32'(dut_rd(32'h40)), 32'h11);
    checkOutput("rst-store RAM[0x41]", 32'(dut_rd(32'h41)), 32'h22);
    checkOutput("rst-store RAM[0x42]", 32'(dut_rd(32'h42)), 32'hE2);
    checkOutput("rst-store RAM[0x43]", 32'(dut_rd(32'h43)), 32'hE3);

    $display("[TB] fetch after reset");
    applyStimulus(1, 32'h100, 0, 0, 2'b00, 32'h0, 32'h0);
    waitDone(0, 20, n);
    checkOutput("recovery latency", 32'(n), 32'd5);
    checkOutput("recovery if_data", if_data, 32'h00000013);
    applyStimulus(0, 32'h0, 0, 0, 2'b00, 32'h0, 32'h0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
